// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_sched controller.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEF = 8;
    localparam int unsigned BURST_W   = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/clk_div_counter.sv
// Period counter: holds the active and pending ratios and emits a wrap strobe
// on the edge where cnt reaches div_reg.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             clear,
    input  logic             cfg_accept,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             wrap,
    output logic             pend_valid
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] pend_div;

    assign wrap = active && (cnt == div_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            div_reg    <= '0;
            pend_div   <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (clear || wrap) begin
                cnt <= '0;
            end else if (active) begin
                cnt <= cnt + 1'b1;
            end

            // Accept only happens while nothing is pending, so it never
            // collides with the apply below.
            if (cfg_accept && !active) begin
                div_reg <= cfg_div;
            end else if (cfg_accept) begin
                pend_div   <= cfg_div;
                pend_valid <= 1'b1;
            end

            if (wrap && pend_valid) begin
                div_reg    <= pend_div;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Programmable clock-divider controller: tick enable plus glitch-free divided output.
// Optional burst mode (burst_len/done ports) enabled by defining CLKDIV_BURST_EN.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic               div_out,
    output logic               busy
`ifdef CLKDIV_BURST_EN
    ,
    input  logic [BURST_W-1:0] burst_len,
    output logic               done
`endif
);

    state_t state;
    logic   active;
    logic   wrap;
    logic   pend_valid;
    logic   cfg_accept;
    logic   start_edge;
    logic   burst_last;

    assign active     = (state != IDLE);
    assign busy       = active;
    assign cfg_ready  = !pend_valid;
    assign cfg_accept = cfg_valid && cfg_ready;
    assign start_edge = (state == IDLE) && start;

    clk_div_counter #(.DIV_W(DIV_W)) u_counter (
        .clk        (clk),
        .rst        (rst),
        .active     (active),
        .clear      (start_edge),
        .cfg_accept (cfg_accept),
        .cfg_div    (cfg_div),
        .wrap       (wrap),
        .pend_valid (pend_valid)
    );

`ifdef CLKDIV_BURST_EN
    logic [BURST_W-1:0] burst_left;
    logic               burst_on;

    assign burst_last = burst_on && wrap && (burst_left == BURST_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_left <= '0;
            burst_on   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= burst_last;
            if (start_edge) begin
                burst_left <= burst_len;
                burst_on   <= (burst_len != '0);
            end else if (burst_last) begin
                burst_on <= 1'b0;
            end else if (burst_on && wrap) begin
                burst_left <= burst_left - 1'b1;
            end
        end
    end
`else
    assign burst_last = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= 1'b0;
            div_out <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                div_out <= ~div_out;
            end
            case (state)
                IDLE: begin
                    if (start) state <= IDLE == IDLE ? RUN : IDLE;
                end
                RUN: begin
                    if (burst_last) begin
                        state   <= IDLE;
                        div_out <= 1'b0;
                    end else if (stop) begin
                        state <= STOPPING;
                    end
                end
                STOPPING: begin
                    // The idle transition only fires on a falling tick, so the
                    // toggle above already leaves div_out low.
                    if (burst_last) begin
                        state   <= IDLE;
                        div_out <= 1'b0;
                    end else if (start) begin
                        state <= RUN;
                    end else if (wrap && div_out) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
